// File: rtl/vp_mac_accum.sv
// -----------------------------------------------------------------------------
// vp_mac_accum
//
// Purpose:
//   Consumes VPEncoder's left/right ping-pong buffers (3 lanes each: addr, w,
//   ia). One buffer is latched at a time, in strict left/right alternation. The
//   lanes are multiplied (w*ia) one per cycle and accumulated into a psum bank
//   indexed by addr field 0. A drain request streams the whole bank out, one
//   entry per cycle, and clears each entry as it is presented.
//
// Configuration:
//   VP_MAC_SAT_EN  defined     -> accumulation saturates to the signed ACC_W
//                                 range and any clamp sets the sticky o_sat.
//                  not defined -> two's-complement wrap, o_sat tied to 0.
//
// Ports:
//   i_clk, i_rst              rising-edge clock, asynchronous active-high reset
//   i_left_ready/i_right_ready level: the buffer on that side holds valid data
//   i_addr_*  [lane][field]   lane addresses; only field 0 is used here
//   i_w_*, i_ia_*             signed 16-bit weight / activation per lane
//   o_left_ack/o_right_ack    1-cycle pulse: that side was latched, may refill
//   i_drain                   1-cycle pulse: stream out and clear the bank
//   o_psum_valid/idx/data     streamed psum entry (idx/data are 0 when idle)
//   o_drain_done              1-cycle pulse the cycle after the last entry
//   o_busy                    FSM is not IDLE
//   o_sat                     sticky saturation flag (cleared by reset only)
//   o_dbg_state               raw FSM state, for checkers
//
// Handshake: a side's ready is a level that must stay asserted, with its data
// stable, until that side's ack pulse; data is sampled only on the cycle the
// FSM leaves IDLE for MAC0. Requests arriving while busy stay pending (ready)
// or are dropped (i_drain). The lane schedule is fixed to 3 lanes (LANES=3).
// -----------------------------------------------------------------------------
module vp_mac_accum #(
    parameter int LANES      = 3,
    parameter int ACC_W      = 32,
    parameter int PSUM_DEPTH = 128,
    parameter int IDX_W      = $clog2(PSUM_DEPTH)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_left_ready,
    input  logic                             i_right_ready,
    input  logic [LANES-1:0][2:0][IDX_W-1:0] i_addr_left,
    input  logic signed [LANES-1:0][15:0]    i_w_left,
    input  logic signed [LANES-1:0][15:0]    i_ia_left,
    input  logic [LANES-1:0][2:0][IDX_W-1:0] i_addr_right,
    input  logic signed [LANES-1:0][15:0]    i_w_right,
    input  logic signed [LANES-1:0][15:0]    i_ia_right,
    output logic                             o_left_ack,
    output logic                             o_right_ack,
    input  logic                             i_drain,
    output logic                             o_psum_valid,
    output logic [IDX_W-1:0]                 o_psum_idx,
    output logic signed [ACC_W-1:0]          o_psum_data,
    output logic                             o_drain_done,
    output logic                             o_busy,
    output logic                             o_sat,
    output logic [2:0]                       o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC0  = 3'd1,
        S_MAC1  = 3'd2,
        S_MAC2  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PSUM_DEPTH - 1);

    state_t                  state_q, state_d;
    logic                    expect_right_q;
    logic                    left_ack_q, right_ack_q;
    logic                    done_q;
    logic [IDX_W-1:0]        drain_idx_q;
    logic                    latch_left, latch_right;

    logic [IDX_W-1:0]        addr_q [LANES];
    logic signed [15:0]      w_q    [LANES];
    logic signed [15:0]      ia_q   [LANES];
    logic signed [ACC_W-1:0] psum_q [PSUM_DEPTH];

    logic [1:0]              lane_sel;
    logic                    mac_active;
    logic                    lane_write;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] cur_psum;
    logic signed [ACC_W-1:0] acc_d;

    // Address fields 1 and 2 belong to future spatial variants.
    logic unused_addr_fields;
    always_comb begin
        unused_addr_fields = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            unused_addr_fields = unused_addr_fields
                ^ (^i_addr_left[k][2:1]) ^ (^i_addr_right[k][2:1]);
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        latch_left  = 1'b0;
        latch_right = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Drain wins over buffers; only the expected side may be taken.
                if (i_drain) begin
                    state_d = S_DRAIN;
                end else if (!expect_right_q && i_left_ready) begin
                    latch_left = 1'b1;
                    state_d    = S_MAC0;
                end else if (expect_right_q && i_right_ready) begin
                    latch_right = 1'b1;
                    state_d     = S_MAC0;
                end
            end
            S_MAC0:  state_d = S_MAC1;
            S_MAC1:  state_d = S_MAC2;
            S_MAC2:  state_d = S_IDLE;
            S_DRAIN: if (drain_idx_q == LAST_IDX) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ control regs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            expect_right_q <= 1'b0;
            left_ack_q     <= 1'b0;
            right_ack_q    <= 1'b0;
            done_q         <= 1'b0;
            drain_idx_q    <= '0;
        end else begin
            left_ack_q  <= latch_left;
            right_ack_q <= latch_right;
            done_q      <= (state_q == S_DRAIN) && (drain_idx_q == LAST_IDX);
            if (latch_left || latch_right) begin
                expect_right_q <= ~expect_right_q;
            end
            // Wraps back to 0 on the last entry, ready for the next drain.
            if (state_q == S_DRAIN) begin
                drain_idx_q <= drain_idx_q + 1'b1;
            end else begin
                drain_idx_q <= '0;
            end
        end
    end

    // -------------------------------------------------------- lane latch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < LANES; k++) begin
                addr_q[k] <= '0;
                w_q[k]    <= '0;
                ia_q[k]   <= '0;
            end
        end else if (latch_left) begin
            for (int k = 0; k < LANES; k++) begin
                addr_q[k] <= i_addr_left[k][0];
                w_q[k]    <= $signed(i_w_left[k]);
                ia_q[k]   <= $signed(i_ia_left[k]);
            end
        end else if (latch_right) begin
            for (int k = 0; k < LANES; k++) begin
                addr_q[k] <= i_addr_right[k][0];
                w_q[k]    <= $signed(i_w_right[k]);
                ia_q[k]   <= $signed(i_ia_right[k]);
            end
        end
    end

    // ------------------------------------------------------- MAC datapath
    always_comb begin
        lane_sel = 2'd0;
        case (state_q)
            S_MAC1:  lane_sel = 2'd1;
            S_MAC2:  lane_sel = 2'd2;
            default: lane_sel = 2'd0;
        endcase
    end

    assign mac_active = (state_q == S_MAC0) || (state_q == S_MAC1) || (state_q == S_MAC2);
    // Zero weight or activation marks a padding lane: no bank write at all.
    assign lane_write = mac_active && (w_q[lane_sel] != 16'sd0) && (ia_q[lane_sel] != 16'sd0);
    assign prod       = 32'(w_q[lane_sel]) * 32'(ia_q[lane_sel]);
    assign cur_psum   = psum_q[addr_q[lane_sel]];

`ifdef VP_MAC_SAT_EN
    logic signed [ACC_W:0] sum_wide;
    logic                  overflow;
    logic                  sat_q;

    always_comb begin
        sum_wide = (ACC_W+1)'(cur_psum) + (ACC_W+1)'(prod);
        // Extra sign bit disagreeing with the ACC_W sign bit means overflow.
        overflow = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (!overflow) begin
            acc_d = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            acc_d = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_d = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sat_q <= 1'b0;
        end else if (lane_write && overflow) begin
            sat_q <= 1'b1;
        end
    end

    assign o_sat = sat_q;
`else
    assign acc_d = cur_psum + ACC_W'(prod);
    assign o_sat = 1'b0;
`endif

    // ---------------------------------------------------------- psum bank
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < PSUM_DEPTH; i++) begin
                psum_q[i] <= '0;
            end
        end else if (lane_write) begin
            psum_q[addr_q[lane_sel]] <= acc_d;
        end else if (state_q == S_DRAIN) begin
            // Cleared on the same edge that ends its presentation.
            psum_q[drain_idx_q] <= '0;
        end
    end

    // ------------------------------------------------------------ outputs
    assign o_left_ack   = left_ack_q;
    assign o_right_ack  = right_ack_q;
    assign o_drain_done = done_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_psum_valid = (state_q == S_DRAIN);
    assign o_psum_idx   = o_psum_valid ? drain_idx_q : '0;
    assign o_psum_data  = o_psum_valid ? psum_q[drain_idx_q] : '0;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_vp_mac_accum.sv
// -----------------------------------------------------------------------------
// tb_vp_mac_accum
//
// Self-checking bench for vp_mac_accum. A bench-side psum model (plain integer
// arithmetic, saturating when VP_MAC_SAT_EN is defined) is updated whenever a
// buffer is acknowledged; a drain request pushes the model's 128 entries into
// exp_q, and each streamed entry pops and compares one of them.
// Inputs are driven 1 time unit after a rising edge, outputs sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_vp_mac_accum;

    localparam longint MAX_V = 64'sd2147483647;
    localparam longint MIN_V = -MAX_V - 64'sd1;

    logic                  clk;
    logic                  rst;
    logic                  left_ready, right_ready;
    logic [2:0][2:0][6:0]  addr_left, addr_right;
    logic [2:0][15:0]      w_left, ia_left, w_right, ia_right;
    logic                  drain;
    logic                  left_ack, right_ack;
    logic                  psum_valid;
    logic [6:0]            psum_idx;
    logic [31:0]           psum_data;
    logic                  drain_done, busy, sat;
    logic [2:0]            dbg_state;

    int          n_tests;
    int          n_fail;
    logic [38:0] exp_q[$];
    int          model[128];
    bit          model_sat;
    bit          side_right;

    vp_mac_accum dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_left_ready  (left_ready),
        .i_right_ready (right_ready),
        .i_addr_left   (addr_left),
        .i_w_left      (w_left),
        .i_ia_left     (ia_left),
        .i_addr_right  (addr_right),
        .i_w_right     (w_right),
        .i_ia_right    (ia_right),
        .o_left_ack    (left_ack),
        .o_right_ack   (right_ack),
        .i_drain       (drain),
        .o_psum_valid  (psum_valid),
        .o_psum_idx    (psum_idx),
        .o_psum_data   (psum_data),
        .o_drain_done  (drain_done),
        .o_busy        (busy),
        .o_sat         (sat),
        .o_dbg_state   (dbg_state)
    );

    // ------------------------------------------------ clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, required finish before 600000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------- model
    function automatic int mac_model(input int cur, input longint p);
        longint s;
        s = longint'(cur) + p;
`ifdef VP_MAC_SAT_EN
        if (s > MAX_V) begin
            model_sat = 1'b1;
            return int'(MAX_V);
        end
        if (s < MIN_V) begin
            model_sat = 1'b1;
            return int'(MIN_V);
        end
`endif
        return int'(s);
    endfunction

    task automatic apply_model(input logic [2:0][6:0] a, input logic [2:0][15:0] w,
                               input logic [2:0][15:0] ia);
        for (int k = 0; k < 3; k++) begin
            if (w[k] != 16'd0 && ia[k] != 16'd0) begin
                longint p;
                p = longint'($signed(w[k])) * longint'($signed(ia[k]));
                model[a[k]] = mac_model(model[a[k]], p);
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 128; i++) model[i] = 0;
        model_sat  = 1'b0;
        side_right = 1'b0;
        exp_q.delete();
    endtask

    // ------------------------------------------------------- driver tasks
    task automatic idle_inputs();
        left_ready  = 1'b0;
        right_ready = 1'b0;
        drain       = 1'b0;
        addr_left   = '0;
        addr_right  = '0;
        w_left      = '0;
        ia_left     = '0;
        w_right     = '0;
        ia_right    = '0;
    endtask

    task automatic reset_dut(input string tag);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rst_lack"},  left_ack, 0);
        check({tag, "_rst_rack"},  right_ack, 0);
        check({tag, "_rst_valid"}, psum_valid, 0);
        check({tag, "_rst_idx"},   psum_idx, 0);
        check({tag, "_rst_data"},  psum_data, 0);
        check({tag, "_rst_done"},  drain_done, 0);
        check({tag, "_rst_busy"},  busy, 0);
        check({tag, "_rst_sat"},   sat, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        @(negedge clk);
        while (busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_idle"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0][2:0][6:0] build_addr(input logic [2:0][6:0] a);
        logic [2:0][2:0][6:0] full;
        for (int k = 0; k < 3; k++) begin
            full[k][0] = a[k];
            full[k][1] = 7'($urandom_range(0, 127));
            full[k][2] = 7'($urandom_range(0, 127));
        end
        return full;
    endfunction

    // Offers one buffer on the currently expected side and checks the ack
    // latency (in falling edges after the ready is raised).
    task automatic send_buf(input string tag, input logic [2:0][6:0] a,
                            input logic [2:0][15:0] w, input logic [2:0][15:0] ia,
                            input int exp_lat);
        int lat;
        bit got, wrong;
        lat = 0; got = 1'b0; wrong = 1'b0;
        if (side_right) begin
            addr_right = build_addr(a); w_right = w; ia_right = ia; right_ready = 1'b1;
        end else begin
            addr_left = build_addr(a); w_left = w; ia_left = ia; left_ready = 1'b1;
        end
        while (!got && lat < 50) begin
            @(negedge clk);
            lat++;
            if (side_right ? right_ack : left_ack) got = 1'b1;
            if (side_right ? left_ack : right_ack) wrong = 1'b1;
        end
        check({tag, "_ack"}, got, 1);
        check({tag, "_ack_lat"}, lat, exp_lat);
        check({tag, "_wrong_ack"}, wrong, 0);
        apply_model(a, w, ia);
        @(posedge clk);
        #1;
        // Scrambled data after the ack must not reach the bank.
        if (side_right) begin
            right_ready = 1'b0; w_right = 48'($urandom); ia_right = 48'($urandom);
        end else begin
            left_ready = 1'b0; w_left = 48'($urandom); ia_left = 48'($urandom);
        end
        @(negedge clk);
        check({tag, "_ack_pulse"}, side_right ? right_ack : left_ack, 0);
        side_right = ~side_right;
        @(posedge clk);
        #1;
    endtask

    // Right raised first (pre cycles alone), then left: left must win, right
    // follows 4 cycles later. Expects the DUT idle and expecting left.
    task automatic send_pair(input string tag,
                             input logic [2:0][6:0] la, input logic [2:0][15:0] lw,
                             input logic [2:0][15:0] lia,
                             input logic [2:0][6:0] ra, input logic [2:0][15:0] rw,
                             input logic [2:0][15:0] ria, input int pre);
        int cyc, left_at, right_at;
        bit early;
        early = 1'b0;
        addr_right = build_addr(ra); w_right = rw; ia_right = ria; right_ready = 1'b1;
        for (int i = 0; i < pre; i++) begin
            @(negedge clk);
            if (left_ack || right_ack || busy) early = 1'b1;
            @(posedge clk);
            #1;
        end
        check({tag, "_no_early_ack"}, early, 0);
        addr_left = build_addr(la); w_left = lw; ia_left = lia; left_ready = 1'b1;
        cyc = 0; left_at = -1; right_at = -1;
        while (right_at < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (left_ack && left_at < 0) left_at = cyc;
            if (right_ack) right_at = cyc;
            @(posedge clk);
            #1;
            if (left_at >= 0) left_ready = 1'b0;
            if (right_at >= 0) right_ready = 1'b0;
        end
        check({tag, "_left_at"}, left_at, 2);
        check({tag, "_right_at"}, right_at, left_at + 4);
        apply_model(la, lw, lia);
        apply_model(ra, rw, ria);
    endtask

    // Requests a drain; the scoreboard is filled from the model at that point.
    task automatic do_drain(input string tag);
        int cyc, seen;
        bit done;
        logic [38:0] e;
        wait_idle(tag);
        for (int i = 0; i < 128; i++) begin
            exp_q.push_back({7'(i), 32'(model[i])});
            model[i] = 0;
        end
        drain = 1'b1;
        @(posedge clk);
        #1;
        drain = 1'b0;
        cyc = 0; seen = 0; done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (psum_valid) begin
                seen++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_idx"}, psum_idx, e[38:32]);
                    check({tag, "_data"}, psum_data, e[31:0]);
                end else begin
                    check({tag, "_extra_entry"}, psum_valid, 0);
                end
            end
            if (drain_done) begin
                done = 1'b1;
                check({tag, "_busy_at_done"}, busy, 0);
                check({tag, "_valid_at_done"}, psum_valid, 0);
            end
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_count"}, seen, 128);
        check({tag, "_left_in_q"}, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------- sequence
    initial begin
        logic [2:0][6:0]  t1_a, same5, zero_a, t6_a;
        logic [2:0][15:0] t1_w, t1_ia, ones, big;
        int  c, n_valid;
        bit  found, bad;

        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_inputs();
        clear_model();

        t1_a  = {7'd9, 7'd7, 7'd5};
        t1_w  = {16'd4, 16'd3, 16'd2};
        t1_ia = {16'd10, 16'd10, 16'd10};
        same5 = {7'd5, 7'd5, 7'd5};
        ones  = {16'd1, 16'd1, 16'd1};
        zero_a = '0;
        big   = {16'h7FFF, 16'h7FFF, 16'h7FFF};
        t6_a  = {7'd100, 7'd41, 7'd3};

        // 1: single left buffer, then drain.
        reset_dut("t1");
        send_buf("t1", t1_a, t1_w, t1_ia, 2);
        do_drain("t1");

        // 2: both sides ready together, left first.
        reset_dut("t2");
        send_pair("t2", t1_a, t1_w, t1_ia, same5, ones, ones, 0);
        do_drain("t2");

        // 3: right alone is never taken first.
        reset_dut("t3");
        send_pair("t3", t1_a, t1_w, t1_ia, same5, ones, ones, 20);
        do_drain("t3");

        // 4: large products into one entry, three back-to-back buffers.
        send_buf("t4_b0", zero_a, big, big, 2);
        send_buf("t4_b1", zero_a, big, big, 3);
        send_buf("t4_b2", zero_a, {16'h8000, 16'h0000, 16'h7FFF}, {16'h7FFF, 16'h1234, 16'h7FFF}, 3);
        wait_idle("t4");
        check("t4_sat", sat, model_sat);
        do_drain("t4");

        // 5: back-to-back drains, then a drain request during MAC1.
        do_drain("t5_again");
        do_drain("t5_zeros");
        wait_idle("t5_mac");
        if (side_right) begin
            addr_right = build_addr(t1_a); w_right = t1_w; ia_right = t1_ia; right_ready = 1'b1;
        end else begin
            addr_left = build_addr(t1_a); w_left = t1_w; ia_left = t1_ia; left_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_mac_ack", side_right ? right_ack : left_ack, 1);
        @(posedge clk);
        #1;
        left_ready  = 1'b0;
        right_ready = 1'b0;
        drain       = 1'b1;
        @(posedge clk);
        #1;
        drain = 1'b0;
        apply_model(t1_a, t1_w, t1_ia);
        side_right = ~side_right;
        n_valid = 0;
        bad = 1'b0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (psum_valid) n_valid++;
            if (drain_done) bad = 1'b1;
        end
        check("t5_dropped_valid", n_valid, 0);
        check("t5_dropped_done", bad, 0);
        check("t5_dropped_busy", busy, 0);
        @(posedge clk);
        #1;
        do_drain("t5_after");

        // 6: reset in the middle of a drain.
        send_buf("t6", t6_a, {16'hFFFE, 16'd7, 16'd300}, {16'd50, 16'hFFF9, 16'd11}, 2);
        wait_idle("t6");
        drain = 1'b1;
        @(posedge clk);
        #1;
        drain = 1'b0;
        c = 0;
        found = 1'b0;
        while (!found && c < 200) begin
            @(negedge clk);
            c++;
            if (psum_valid && psum_idx == 7'd40) found = 1'b1;
        end
        check("t6_reach_idx40", found, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", psum_valid, 0);
        check("t6_rst_idx", psum_idx, 0);
        check("t6_rst_data", psum_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", drain_done, 0);
        check("t6_rst_sat", sat, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        bad = 1'b0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (drain_done || psum_valid || busy) bad = 1'b1;
        end
        check("t6_no_done_after_rst", bad, 0);
        @(posedge clk);
        #1;
        do_drain("t6_bank_zero");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
